// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit serializer.
// The ABORT state exists only when USB_TX_ABORT_EN is defined.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
`ifdef USB_TX_ABORT_EN
    , ST_ABORT
`endif
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;
  localparam int         EOP_SE0_BITS = 2;
  localparam int         ABORT_ONES   = 8;

  // Line states as {d_plus, d_minus}
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  function automatic logic [1:0] nrzi_line(input logic level_j);
    return level_j ? J : K;
  endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Free-running USB bit-period counter with synchronous clear; bit_strobe marks
// the last system clock of each bit period. Mirrors the RX bit timer.
module usb_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  output logic bit_strobe
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr || cnt_q == CNT_MAX) cnt_d = '0;
    else                         cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bit_strobe = (cnt_q == CNT_MAX);

endmodule

// File: rtl/usb_tx_serializer.sv
// USB full-speed TX serializer: SYNC, LSB-first payload, bit stuffing, NRZI, EOP.
// Define USB_TX_ABORT_EN to send an 8-bit stuff-violation abort on underrun.
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  tx_state_e  state_q, state_d;
  logic [1:0] line_q, line_d;
  logic       level_q, level_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       hold_last_q, hold_last_d;
  logic       last_seen_q, last_seen_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

  logic       bit_strobe, timer_clr, accept, fetch;
  logic       send_bit, bit_val, base_level;
  logic [2:0] base_ones;

  usb_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr       (timer_clr),
    .bit_strobe(bit_strobe)
  );

  assign tx_ready = !hold_full_q && (state_q == ST_SYNC || state_q == ST_DATA);
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    level_d     = level_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    hold_last_d = hold_last_q;
    last_seen_d = last_seen_q;
    bit_idx_d   = bit_idx_q;
    ones_d      = ones_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    timer_clr   = 1'b0;
    fetch       = 1'b0;
    send_bit    = 1'b0;
    bit_val     = 1'b0;
    base_level  = level_q;
    base_ones   = ones_q;

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
      hold_last_d = tx_last;
    end

    case (state_q)
      ST_IDLE: begin
        line_d = J;
        if (tx_start) begin
          // NRZI reference restarts at J; first SYNC bit hits the line on this edge
          state_d     = ST_SYNC;
          busy_d      = 1'b1;
          timer_clr   = 1'b1;
          bit_idx_d   = 3'd0;
          hold_full_d = 1'b0;
          last_seen_d = 1'b0;
          send_bit    = 1'b1;
          bit_val     = SYNC_BYTE[0];
          base_level  = 1'b1;
          base_ones   = 3'd0;
        end
      end
      ST_SYNC: if (bit_strobe) begin
        if (bit_idx_q == 3'd7) fetch = 1'b1;
        else begin
          bit_idx_d = bit_idx_q + 3'd1;
          send_bit  = 1'b1;
          bit_val   = SYNC_BYTE[bit_idx_d];
        end
      end
      ST_DATA: if (bit_strobe) begin
        if (ones_q == STUFF_LIMIT) begin
          state_d  = ST_STUFF;
          send_bit = 1'b1;
          bit_val  = 1'b0;
        end else if (bit_idx_q == 3'd7) begin
          fetch = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
          send_bit  = 1'b1;
          bit_val   = shift_q[bit_idx_d];
        end
      end
      ST_STUFF: if (bit_strobe) begin
        // bit_idx still points at the bit that preceded the stuffed 0
        if (bit_idx_q == 3'd7) fetch = 1'b1;
        else begin
          state_d   = ST_DATA;
          bit_idx_d = bit_idx_q + 3'd1;
          send_bit  = 1'b1;
          bit_val   = shift_q[bit_idx_d];
        end
      end
      ST_EOP_SE0: if (bit_strobe) begin
        if (cnt_q == 3'(EOP_SE0_BITS - 1)) begin
          state_d = ST_EOP_J;
          line_d  = J;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_EOP_J: if (bit_strobe) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
`ifdef USB_TX_ABORT_EN
      ST_ABORT: if (bit_strobe) begin
        if (cnt_q == 3'(ABORT_ONES - 1)) begin
          state_d = ST_EOP_SE0;
          line_d  = SE0;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // A byte accepted on the fetch cycle bypasses the holding register
    if (fetch) begin
      if (hold_full_q || accept) begin
        shift_d     = hold_full_q ? hold_q : tx_data;
        last_seen_d = hold_full_q ? hold_last_q : tx_last;
        hold_full_d = 1'b0;
        state_d     = ST_DATA;
        bit_idx_d   = 3'd0;
        send_bit    = 1'b1;
        bit_val     = shift_d[0];
      end else if (last_seen_q) begin
        state_d = ST_EOP_SE0;
        line_d  = SE0;
        cnt_d   = 3'd0;
      end else begin
        error_d = 1'b1;
        cnt_d   = 3'd0;
`ifdef USB_TX_ABORT_EN
        state_d = ST_ABORT;
`else
        state_d = ST_EOP_SE0;
        line_d  = SE0;
`endif
      end
    end

    if (send_bit) begin
      level_d = bit_val ? base_level : !base_level;
      line_d  = nrzi_line(level_d);
      ones_d  = bit_val ? base_ones + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      line_q      <= J;
      level_q     <= 1'b1;
      hold_full_q <= 1'b0;
      last_seen_q <= 1'b0;
      bit_idx_q   <= 3'd0;
      ones_q      <= 3'd0;
      cnt_q       <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      level_q     <= level_d;
      hold_full_q <= hold_full_d;
      last_seen_q <= last_seen_d;
      bit_idx_q   <= bit_idx_d;
      ones_q      <= ones_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Payload registers carry no reset; hold_full_q qualifies their contents
  always_ff @(posedge clk) begin
    shift_q     <= shift_d;
    hold_q      <= hold_d;
    hold_last_q <= hold_last_d;
  end

  assign d_plus   = line_q[1];
  assign d_minus  = line_q[0];
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_error = error_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer: per-bit line symbols (J/K/0) are
// sampled mid-period and compared against hand-derived packet images.
`timescale 1ns/1ps
module tb_usb_tx_serializer;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_error;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  usb_tx_serializer #(.CLKS_PER_BIT(N)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_last (tx_last),
    .tx_ready(tx_ready),
    .d_plus  (d_plus),
    .d_minus (d_minus),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx_error(tx_error)
  );

  typedef struct {
    string      name;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
    bit         last;
    int         b1_at;
    string      exp;
    int         exp_err;
  } vec_t;

  vec_t vecs[7];

  function automatic string line_ch();
    if (d_plus && !d_minus)  return "J";
    if (!d_plus && d_minus)  return "K";
    if (!d_plus && !d_minus) return "0";
    return "1";
  endfunction

  task automatic check(input string name, input bit ok, input string got, input string req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %s, required %s", name, got, req);
    end
  endtask

  task automatic run_entry(input vec_t v);
    string got;
    int    bi;
    int    errs;
    int    done_j;
    bit    busy_bad;
    got = "";
    bi = 0;
    errs = 0;
    done_j = -1;
    busy_bad = 1'b0;
    @(negedge clk);
    tx_start = 1'b1;
    for (int j = 0; j < 50 * N && done_j < 0; j++) begin
      @(negedge clk);
      tx_start = (j == 3 * N + 1);  // must be ignored while busy
      if (j == 0)
        check({v.name, ".first_edge"}, line_ch() == "K" && tx_busy,
              $sformatf("%s busy=%0b", line_ch(), tx_busy), "K busy=1");
      if (j % N == N / 2) got = {got, line_ch()};
      if (tx_error) errs++;
      if (tx_done) begin
        done_j = j;
        if (tx_busy) busy_bad = 1'b1;
      end else if (!tx_busy) begin
        busy_bad = 1'b1;
      end
      if (bi < v.nbytes && (bi == 0 || j >= v.b1_at)) begin
        tx_valid = 1'b1;
        tx_data  = (bi == 0) ? v.b0 : v.b1;
        tx_last  = v.last && (bi == v.nbytes - 1);
      end else begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
      end
      if (tx_valid && tx_ready) bi++;
    end
    tx_valid = 1'b0;
    tx_start = 1'b0;
    tx_last  = 1'b0;
    check({v.name, ".line"}, got == v.exp, got, v.exp);
    check({v.name, ".error"}, errs == v.exp_err,
          $sformatf("%0d pulses", errs), $sformatf("%0d pulses", v.exp_err));
    check({v.name, ".done_time"}, done_j == v.exp.len() * N,
          $sformatf("cycle %0d", done_j), $sformatf("cycle %0d", v.exp.len() * N));
    check({v.name, ".busy"}, !busy_bad, $sformatf("%0b", busy_bad), "0");
    repeat (5) @(negedge clk);
  endtask

  initial begin
    string sync_s, abort_s;
    bit    bad;
    int    dones;

    sync_s = "KJKJKJKK";
`ifdef USB_TX_ABORT_EN
    abort_s = "KKKKKKKK";
`else
    abort_s = "";
`endif
    vecs[0] = '{"byte00", 1, 8'h00, 8'h00, 1'b1, 0, {sync_s, "JKJKJKJK", "00J"}, 0};
    vecs[1] = '{"byteFF", 1, 8'hFF, 8'h00, 1'b1, 0, {sync_s, "KKKKKJJJJ", "00J"}, 0};
    vecs[2] = '{"a5_3c_fetch", 2, 8'hA5, 8'h3C, 1'b1, 16 * N - 1,
                {sync_s, "KJJKJJKK", "JKKKKKJK", "00J"}, 0};
    vecs[3] = '{"fc_stuff_eop", 1, 8'hFC, 8'h00, 1'b1, 0, {sync_s, "JKKKKKKKJ", "00J"}, 0};
    vecs[4] = '{"fc_ff_hold", 2, 8'hFC, 8'hFF, 1'b1, 0,
                {sync_s, "JKKKKKKKJ", "JJJJJJKKK", "00J"}, 0};
    vecs[5] = '{"no_payload", 0, 8'h00, 8'h00, 1'b0, 0, {sync_s, abort_s, "00J"}, 1};
    vecs[6] = '{"no_last", 1, 8'h00, 8'h00, 1'b0, 0,
                {sync_s, "JKJKJKJK", abort_s, "00J"}, 1};

    repeat (3) @(negedge clk);
    check("reset_values", d_plus && !d_minus && !tx_ready && !tx_busy && !tx_done && !tx_error,
          $sformatf("dp=%0b dm=%0b rdy=%0b busy=%0b", d_plus, d_minus, tx_ready, tx_busy),
          "dp=1 dm=0 rdy=0 busy=0");
    n_rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!(d_plus && !d_minus && !tx_ready && !tx_busy && !tx_done && !tx_error)) bad = 1'b1;
    end
    check("idle_100", !bad, $sformatf("%0b", bad), "0");

    for (int i = 0; i < 7; i++) run_entry(vecs[i]);

    // Reset asserted mid-DATA
    @(negedge clk);
    tx_start = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tx_last  = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    repeat (10 * N) @(negedge clk);
    check("mid_busy", tx_busy, $sformatf("%0b", tx_busy), "1");
    n_rst = 1'b0;
    #1;
    check("async_reset", d_plus && !d_minus && !tx_busy,
          $sformatf("dp=%0b dm=%0b busy=%0b", d_plus, d_minus, tx_busy), "dp=1 dm=0 busy=0");
    @(negedge clk);
    n_rst = 1'b1;
    dones = 0;
    bad = 1'b0;
    for (int i = 0; i < 30 * N; i++) begin
      @(negedge clk);
      if (tx_done) dones++;
      if (!(d_plus && !d_minus) || tx_busy) bad = 1'b1;
    end
    check("no_done_after_reset", dones == 0, $sformatf("%0d", dones), "0");
    check("idle_after_reset", !bad, $sformatf("%0b", bad), "0");
    run_entry(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
